ahbl_to_apb: RTL
================

Name: ahbl_to_apb

Overview:
AHB-Lite slave to APB3 master bridge for the peripheral segment. It feeds the apbs_* slave ports of the pad control register block and its sibling APB peripherals through the APB splitter. The bridge converts each AHB-Lite transfer into exactly one APB setup/access sequence and stalls the AHB data phase until APB completes. APB errors are converted to the standard two-cycle AHB ERROR response.

Parameters:
W_HADDR, 32, AHB address width
W_PADDR, 20, APB address width; paddr = haddr[W_PADDR-1:0]
W_DATA, 32, data width on both buses

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous assert, active-low
ahbls_hready  input  1  bus HREADY; address phase is valid only when high
ahbls_hready_resp  output  1  this slave's HREADYOUT
ahbls_hresp  output  1  1 = ERROR
ahbls_haddr  input  W_HADDR  address
ahbls_hwrite  input  1  write
ahbls_htrans  input  2  transfer type; bit 1 = NONSEQ/SEQ
ahbls_hsize  input  3  transfer size
ahbls_hwdata  input  W_DATA  write data, valid in data phase
ahbls_hrdata  output  W_DATA  read data
apbm_paddr  output  W_PADDR  APB address
apbm_psel  output  1  select
apbm_penable  output  1  enable
apbm_pwrite  output  1  write
apbm_pwdata  output  W_DATA  write data
apbm_prdata  input  W_DATA  read data
apbm_pready  input  1  ready
apbm_pslverr  input  1  slave error

Behaviour:
- One clock: clk. Reset is asynchronous and active-low: rst_n.
- States: IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2. All outputs are registered or decoded directly from the state register.
- Reset (async, any state including mid-transfer):
  - State = IDLE; psel = penable = pwrite = 0; paddr = 0; pwdata = 0.
  - hrdata = 0; hready_resp = 1; hresp = 0.
  - No APB transfer is completed or retried after reset.
- hready_resp = 1 in IDLE and ERR2, 0 otherwise.
- hresp = 1 in ERR1 and ERR2 only.
- Accept: state is IDLE or ERR2, and ahbls_hready && htrans[1]. On accept:
  - Latch paddr <= haddr[W_PADDR-1:0] and pwrite <= hwrite.
  - Read: -> SETUP.
  - Write with hsize == 3'b010: -> WDATA.
  - Write with hsize != 3'b010: -> ERR1 with no APB activity. APB3 has no strobes, so narrow writes are illegal.
  - Reads of any size are legal; the full word is returned.
- No accept: IDLE stays IDLE; ERR2 -> IDLE. htrans IDLE/BUSY and hready low are both ignored.
- WDATA: pwdata <= hwdata; -> SETUP.
- SETUP: psel = 1, penable = 0; -> ACCESS unconditionally.
- ACCESS: psel = 1, penable = 1.
  - pready = 0: stay in ACCESS. No timeout.
  - pready = 1, pslverr = 0: -> IDLE. If read, hrdata <= prdata.
  - pready = 1, pslverr = 1: -> ERR1. hrdata is unchanged.
- ERR1 -> ERR2 unconditionally.
- psel and penable deassert in the cycle after pready is sampled high. The bridge never issues back-to-back APB transfers without an intervening IDLE state.
- paddr, pwrite and pwdata are held stable from SETUP through the end of ACCESS.
- hrdata holds its last value outside completions.
- Minimum data-phase length, counted from the address-phase cycle to the data-phase hready_resp high:
  - Read: 3 cycles.
  - Word write: 4 cycles.
  - Each APB wait state adds 1 cycle.
  - Error response: 2 further cycles after ACCESS.
- A new transfer presented during ERR2 is accepted, as AHB-Lite requires. A master that cancels by driving htrans = IDLE in ERR2 causes no APB access.
- Upper haddr bits above W_PADDR-1 are ignored; decode is the interconnect's responsibility.

Test Plan:
- Read, zero wait states: NONSEQ read haddr 0x4000_0008 -> APB setup then access with paddr = 0x00008, pwrite = 0; prdata = 0x1234_5678. Required: hready_resp low for 2 cycles, then high with hrdata = 0x1234_5678, hresp = 0.
- Word write, 2 wait states: hwdata = 0x0000_00A5 at haddr 0x4000_0004. Required: pwdata = 0xA5 stable through access; penable high for 3 cycles; hready_resp returns high 6 cycles after the address phase.
- APB error: read with pslverr = 1 at pready. Required: ERR1 (hready_resp = 0, hresp = 1), then ERR2 (hready_resp = 1, hresp = 1), then hresp = 0; hrdata unchanged from previous value.
- Narrow write: hsize = 0 write. Required: psel never asserts; two-cycle ERROR response. A read presented in ERR2 is accepted and completes normally.
- Hready gating: htrans = NONSEQ with ahbls_hready = 0, or htrans = IDLE. Required: no state change, psel stays 0.
- Async reset mid-transfer: assert rst_n low while in ACCESS with pready = 0. Required: psel = penable = 0 immediately, hready_resp = 1, hrdata = 0. After release, a fresh read completes normally.

Source files
------------

// File: rtl/ahbl_to_apb.sv
`default_nettype none
// ============================================================================
//  Module      : ahbl_to_apb
//  Description : AHB-Lite slave to APB3 master bridge; one APB transfer per
//                AHB transfer, AHB data phase stalled until APB completes.
//  Revision    : 1.0  initial release
// ============================================================================
module ahbl_to_apb #(
    parameter int W_HADDR = 32,
    parameter int W_PADDR = 20,
    parameter int W_DATA  = 32
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               ahbls_hready,
    output logic               ahbls_hready_resp,
    output logic               ahbls_hresp,
    input  logic [W_HADDR-1:0] ahbls_haddr,
    input  logic               ahbls_hwrite,
    input  logic [1:0]         ahbls_htrans,
    input  logic [2:0]         ahbls_hsize,
    input  logic [W_DATA-1:0]  ahbls_hwdata,
    output logic [W_DATA-1:0]  ahbls_hrdata,

    output logic [W_PADDR-1:0] apbm_paddr,
    output logic               apbm_psel,
    output logic               apbm_penable,
    output logic               apbm_pwrite,
    output logic [W_DATA-1:0]  apbm_pwdata,
    input  logic [W_DATA-1:0]  apbm_prdata,
    input  logic               apbm_pready,
    input  logic               apbm_pslverr
);

    localparam logic [2:0] C_HSIZE_WORD = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WDATA  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_ERR1   = 3'd4,
        ST_ERR2   = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [W_PADDR-1:0]  r_paddr;
    logic                r_pwrite;
    logic [W_DATA-1:0]   r_pwdata;
    logic [W_DATA-1:0]   r_hrdata;
    logic                w_accept;
    logic                w_apb_done;
    logic                w_unused_htrans;

    // A new address phase may only be taken where HREADYOUT is high.
    assign w_accept = ((r_state == ST_IDLE) || (r_state == ST_ERR2))
                      && ahbls_hready && ahbls_htrans[1];
    assign w_apb_done      = (r_state == ST_ACCESS) && apbm_pready;
    assign w_unused_htrans = ahbls_htrans[0];

    // Address bits above the APB window are decoded by the interconnect.
    generate
        if (W_HADDR > W_PADDR) begin : g_haddr_upper
            logic w_unused_haddr_hi;
            assign w_unused_haddr_hi = ^ahbls_haddr[W_HADDR-1:W_PADDR];
        end else begin : g_haddr_exact
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_ERR2: begin
                if (w_accept) begin
                    if (!ahbls_hwrite) begin
                        w_state_nxt = ST_SETUP;
                    end else if (ahbls_hsize == C_HSIZE_WORD) begin
                        w_state_nxt = ST_WDATA;
                    end else begin
                        // APB3 has no byte strobes, so narrow writes are refused.
                        w_state_nxt = ST_ERR1;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WDATA:  w_state_nxt = ST_SETUP;
            ST_SETUP:  w_state_nxt = ST_ACCESS;
            ST_ACCESS: begin
                if (apbm_pready) begin
                    w_state_nxt = apbm_pslverr ? ST_ERR1 : ST_IDLE;
                end
            end
            ST_ERR1:   w_state_nxt = ST_ERR2;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_paddr  <= '0;
            r_pwrite <= 1'b0;
            r_pwdata <= '0;
            r_hrdata <= '0;
        end else begin
            if (w_accept) begin
                r_paddr  <= ahbls_haddr[W_PADDR-1:0];
                r_pwrite <= ahbls_hwrite;
            end
            if (r_state == ST_WDATA) begin
                r_pwdata <= ahbls_hwdata;
            end
            if (w_apb_done && !apbm_pslverr && !r_pwrite) begin
                r_hrdata <= apbm_prdata;
            end
        end
    end

    assign apbm_paddr        = r_paddr;
    assign apbm_pwrite       = r_pwrite;
    assign apbm_pwdata       = r_pwdata;
    assign apbm_psel         = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
    assign apbm_penable      = (r_state == ST_ACCESS);
    assign ahbls_hready_resp = (r_state == ST_IDLE) || (r_state == ST_ERR2);
    assign ahbls_hresp       = (r_state == ST_ERR1) || (r_state == ST_ERR2);
    assign ahbls_hrdata      = r_hrdata;

endmodule
`default_nettype wire
